hamming74_decode_arbiter: RTL

- Shares one Hamming(7,4) single-error-correcting decode datapath among NUM_REQ requesters.
- Round-robin arbitration selects one requester per cycle; its codeword is decoded and registered into a single output slot with valid/ready backpressure.
- Keeps a saturating count of corrected codewords for status/debug.
- Sits between channel receive FIFOs and the downstream data consumer.

---
 rtl/hamming74_pkg.sv | 18 +
 rtl/hamming74_decode_arbiter_if.sv | 34 +++
 rtl/hamming74_correct_comb.sv | 33 +++
 rtl/hamming74_decode_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: codeword/data/syndrome widths and the
// bit position of each parity and data bit inside a 7-bit codeword.
// Codeword layout: [0]=p1 [1]=p2 [2]=d0 [3]=p3 [4]=d1 [5]=d2 [6]=d3.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P1_BIT = 0;
    localparam int P2_BIT = 1;
    localparam int D0_BIT = 2;
    localparam int P3_BIT = 3;
    localparam int D1_BIT = 4;
    localparam int D2_BIT = 5;
    localparam int D3_BIT = 6;

endpackage

// File: rtl/hamming74_decode_arbiter_if.sv
// Request/result bus of the shared Hamming(7,4) decoder.
//   req_valid/req_codeword/req_ready : per-channel codeword handshake
//   out_valid/out_ready              : result slot handshake
//   out_data/out_chan/out_err/out_syndrome : decoded result fields
// slave  : decoder side (consumes requests, produces results)
// master : environment side (channel FIFOs + downstream consumer)
interface hamming74_decode_arbiter_if
    import hamming74_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CH_W    = 2
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [CW_W*NUM_REQ-1:0] req_codeword;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [CH_W-1:0]         out_chan;
    logic                    out_err;
    logic [SYN_W-1:0]        out_syndrome;

    modport master (
        output req_valid, req_codeword, out_ready,
        input  req_ready, out_valid, out_data, out_chan, out_err, out_syndrome
    );

    modport slave (
        input  req_valid, req_codeword, out_ready,
        output req_ready, out_valid, out_data, out_chan, out_err, out_syndrome
    );

endinterface

// File: rtl/hamming74_correct_comb.sv
// Combinational Hamming(7,4) single-error corrector.
//   codeword : 7-bit input codeword
//   data     : corrected {d3,d2,d1,d0}
//   syndrome : raw syndrome {s2,s1,s0}; value k names erroneous bit k-1
//   err      : syndrome nonzero (a bit was flipped before extraction)
module hamming74_correct_comb
    import hamming74_pkg::*;
(
    input  logic [CW_W-1:0]   codeword,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              err
);

    logic [CW_W-1:0] flip_mask;
    logic [CW_W-1:0] fixed;

    always_comb begin
        syndrome[0] = codeword[P1_BIT] ^ codeword[D0_BIT] ^ codeword[D1_BIT] ^ codeword[D3_BIT];
        syndrome[1] = codeword[P2_BIT] ^ codeword[D0_BIT] ^ codeword[D2_BIT] ^ codeword[D3_BIT];
        syndrome[2] = codeword[P3_BIT] ^ codeword[D1_BIT] ^ codeword[D2_BIT] ^ codeword[D3_BIT];

        flip_mask = '0;
        if (syndrome != '0) begin
            flip_mask = CW_W'(1) << (syndrome - SYN_W'(1));
        end
        fixed = codeword ^ flip_mask;

        data = {fixed[D3_BIT], fixed[D2_BIT], fixed[D1_BIT], fixed[D0_BIT]};
        err  = (syndrome != '0);
    end

endmodule

// File: rtl/hamming74_decode_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) corrector among NUM_REQ
// channels, with a single registered result slot and a saturating count
// of corrected codewords.
//   clk, rst_n : clock, asynchronous active-low reset
//   cnt_clr    : synchronous clear of err_count (wins over increment)
//   err_count  : saturating count of loaded results with out_err=1
//   bus        : request and result handshakes (slave side)
module hamming74_decode_arbiter
    import hamming74_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    parameter int CH_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            err_count,
    hamming74_decode_arbiter_if.slave   bus
);

    localparam int          IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    logic [CH_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]  grant_sel;
    logic              grant_any;
    logic              can_load;
    logic              load;
    logic [CW_W-1:0]   sel_cw;
    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  dec_syn;
    logic              dec_err;
    int unsigned       pos;

    // First valid channel at or after rr_ptr, wrapping; the codeword mux
    // follows the same choice so only one corrector is needed.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = '0;
        sel_cw    = '0;
        pos       = 0;
        for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
            pos = (32'(rr_ptr) + i) % NUM_REQ_U;
            if (!grant_any && bus.req_valid[pos[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_sel = pos[IDX_W-1:0];
                sel_cw    = bus.req_codeword[CW_W*pos[IDX_W-1:0] +: CW_W];
            end
        end
    end

    assign can_load = ~bus.out_valid | bus.out_ready;
    assign load     = can_load & grant_any;

    // rst_n gating keeps req_ready low while reset is held even though the
    // empty slot would otherwise advertise space.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && load) begin
            bus.req_ready[grant_sel] = 1'b1;
        end
    end

    hamming74_correct_comb u_correct (
        .codeword (sel_cw),
        .data     (dec_data),
        .syndrome (dec_syn),
        .err      (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_chan     <= '0;
            bus.out_err      <= 1'b0;
            bus.out_syndrome <= '0;
            rr_ptr           <= '0;
        end else if (load) begin
            bus.out_valid    <= 1'b1;
            bus.out_data     <= dec_data;
            bus.out_chan     <= CH_W'(grant_sel);
            bus.out_err      <= dec_err;
            bus.out_syndrome <= dec_syn;
            rr_ptr           <= CH_W'((32'(grant_sel) + 1) % NUM_REQ_U);
        end else if (bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (load && dec_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
